// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (inhibit, start, 8 data, parity, stop, ack).
// Define PS2_TX_TIMEOUT_EN to abort stalled transfers after START_TIMEOUT / XFER_TIMEOUT.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int XFER_TIMEOUT   = 100000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  if (INHIBIT_CYCLES < 2 || START_TIMEOUT < 1 ||
      XFER_TIMEOUT < 1) begin : g_bad_param
    $error("ps2_host_tx: parameter out of range");
  end

  localparam int IW = $clog2(INHIBIT_CYCLES);
  localparam logic [IW-1:0] INH_PRE  = IW'(INHIBIT_CYCLES - 2);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TMAX = (START_TIMEOUT > XFER_TIMEOUT) ?
                        START_TIMEOUT : XFER_TIMEOUT;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] TO_START = TW'(START_TIMEOUT - 1);
  localparam logic [TW-1:0] TO_XFER  = TW'(XFER_TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
`endif

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RELEASE,
    SHIFT,
    ACK,
    WAIT_IDLE
  } state_t;

  state_t        state;
  logic          clk_meta, sync_clk, clk_prev;
  logic          dat_meta, sync_dat;
  logic          fall;
  logic [IW-1:0] inh_cnt;
  logic [3:0]    edge_cnt;
  logic [9:0]    frame;
  logic          ack_ok;

  // Idle-high reset values keep a falling edge from appearing out of reset.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta <= 1'b1;
      sync_clk <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      sync_dat <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      sync_clk <= clk_meta;
      clk_prev <= sync_clk;
      dat_meta <= ps2_dat_in;
      sync_dat <= dat_meta;
    end
  end

  assign fall = clk_prev & ~sync_clk;

`ifdef PS2_TX_TIMEOUT_EN
  always_comb begin
    tmo_hit = 1'b0;
    if (state == RELEASE && !fall && tmo_cnt == TO_START)
      tmo_hit = 1'b1;
    if ((state == SHIFT || state == ACK) && tmo_cnt == TO_XFER)
      tmo_hit = 1'b1;
  end
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done    <= 1'b0;
      tx_error   <= 1'b0;
      inh_cnt    <= '0;
      edge_cnt   <= '0;
      frame      <= '0;
      ack_ok     <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            frame      <= {1'b1, ~^cmd_byte, cmd_byte};
            inh_cnt    <= '0;
            edge_cnt   <= '0;
            ps2_clk_oe <= 1'b1;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          inh_cnt <= inh_cnt + 1'b1;
          if (inh_cnt == INH_PRE)
            ps2_dat_oe <= 1'b1;
          if (inh_cnt == INH_LAST) begin
            ps2_clk_oe <= 1'b0;
            state      <= RELEASE;
          end
        end
        RELEASE: begin
          if (fall) begin
            ps2_dat_oe <= ~frame[0];
            frame      <= {1'b0, frame[9:1]};
            edge_cnt   <= 4'd1;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          // Edge 10 counting the release edge puts stop on the line.
          if (fall) begin
            ps2_dat_oe <= ~frame[0];
            frame      <= {1'b0, frame[9:1]};
            edge_cnt   <= edge_cnt + 1'b1;
            if (edge_cnt == 4'd9)
              state <= ACK;
          end
        end
        ACK: begin
          if (fall) begin
            ack_ok <= ~sync_dat;
            state  <= WAIT_IDLE;
          end
        end
        WAIT_IDLE: begin
          if (sync_clk && sync_dat) begin
            tx_done   <= ack_ok;
            tx_error  <= ~ack_ok;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            edge_cnt  <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      if (state == INHIBIT || (state == RELEASE && fall))
        tmo_cnt <= '0;
      else if (state == RELEASE || state == SHIFT ||
               state == ACK)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit) begin
        ps2_clk_oe <= 1'b0;
        ps2_dat_oe <= 1'b0;
        tx_done    <= 1'b0;
        tx_error   <= 1'b1;
        cmd_ready  <= 1'b1;
        busy       <= 1'b0;
        edge_cnt   <= '0;
        tmo_cnt    <= '0;
        state      <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector PS/2 device model.
// Covers frames, ack/nack, inhibit timing, busy request masking and mid-transfer reset.
module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int STO  = 300;
  localparam int XTO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cmd_byte;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       ps2_clk_in, ps2_dat_in;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic       busy, tx_done, tx_error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;

  always #10 clk = ~clk;

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .cmd_byte  (cmd_byte),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy      (busy),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int run_len = 0, rise_at = 0;
  int last_len = 0, last_rise = 0;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
    if (ps2_clk_oe) begin
      run_len++;
      if (ps2_dat_oe && rise_at == 0) rise_at = run_len;
    end else if (run_len != 0) begin
      last_len  = run_len;
      last_rise = rise_at;
      run_len   = 0;
      rise_at   = 0;
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    cmd_byte  = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_release(output logic ok);
    int t = 0;
    while (!(busy && !ps2_clk_oe && ps2_dat_oe) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    ok = (t < 20000);
    if (!ok) chk("release_seen", 0, 1);
  endtask

  task automatic dev_xfer(input logic ack, output logic [10:0] seen);
    logic ok;
    int t;
    seen = '0;
    wait_release(ok);
    if (!ok) return;
    repeat (30) @(negedge clk);
    seen[0] = ps2_dat_in;
    for (int k = 1; k <= 10; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      seen[k] = ps2_dat_in;
      repeat (HALF) @(negedge clk);
    end
    dev_dat = ack;
    repeat (5) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (5) @(negedge clk);
    dev_dat = 1'b1;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("idle_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic        ack;
    logic [10:0] frame;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [10:0] seen;
    logic        ok;
    int d0, e0, n;

    vt[0] = '{8'hED, 1'b0, 11'h7DA, 1'b1, 1'b0};
    vt[1] = '{8'h00, 1'b0, 11'h600, 1'b1, 1'b0};
    vt[2] = '{8'hA5, 1'b1, 11'h74A, 1'b0, 1'b1};
    vt[3] = '{8'h01, 1'b0, 11'h402, 1'b1, 1'b0};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_byte  = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_state",
        {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe, tx_done, tx_error},
        6'b100000);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(vt[i].cmd);
      repeat (100) @(negedge clk);
      cmd_byte  = ~vt[i].cmd;
      cmd_valid = 1'b1;
      repeat (3) @(negedge clk);
      cmd_valid = 1'b0;
      dev_xfer(vt[i].ack, seen);
      repeat (10) @(negedge clk);
      chk($sformatf("frame_%0h", vt[i].cmd), seen, vt[i].frame);
      chk("inhibit_len", last_len, INH);
      chk("start_rise", last_rise, INH);
      chk("done_pulses", done_cnt - d0, vt[i].exp_done);
      chk("err_pulses", err_cnt - e0, vt[i].exp_err);
      chk("post_state",
          {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    end

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h5A);
    wait_release(ok);
    repeat (30) @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    chk("mid_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_release",
        {ps2_clk_oe, ps2_dat_oe, busy, cmd_ready}, 4'b0001);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

    d0 = done_cnt;
    send(8'hFF);
    dev_xfer(1'b0, seen);
    repeat (10) @(negedge clk);
    chk("frame_ff", seen, 11'h7FE);
    chk("ff_done", done_cnt - d0, 1);

`ifdef PS2_TX_TIMEOUT_EN
    e0 = err_cnt;
    send(8'h12);
    wait_release(ok);
    n = 0;
    while (!tx_error && n < STO + 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_timeout", n, STO);
    chk("timeout_state",
        {cmd_ready, busy, ps2_clk_oe, ps2_dat_oe}, 4'b1000);
    repeat (5) @(negedge clk);
    chk("timeout_err", err_cnt - e0, 1);
`endif

    chk("done_err_overlap", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
